// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ctrl_pkg
//  Brief   : Microinstruction field layout and select codes for the sequencer
//  Rev     : 1.0  initial release
// ============================================================================
package ctrl_pkg;

  localparam int SRC_LSB  = 0;
  localparam int DST_LSB  = 3;
  localparam int END_BIT  = 6;
  localparam int WAIT_BIT = 7;
  localparam int HALT_BIT = 8;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_NONE = 3'd0;
  localparam logic [CODE_W-1:0] CODE_IR   = 3'd7;

  // Packed MSB-first so the field offsets match the *_LSB / *_BIT positions above.
  typedef struct packed {
    logic [6:0]        rsvd;
    logic              halt;
    logic              wait_mem;
    logic              last;
    logic [CODE_W-1:0] dst;
    logic [CODE_W-1:0] src;
  } uinst_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/onehot_bar_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : onehot_bar_decoder
//  Brief   : N-way active-low one-hot decoder with active-low enable (138-style)
//  Rev     : 1.0  initial release
// ============================================================================
module onehot_bar_decoder #(
  parameter int NUM_OUT  = 8,
  parameter int SEL_BITS = $clog2(NUM_OUT)
) (
  input  logic [SEL_BITS-1:0] i_sel,
  input  logic                i_en_bar,
  output logic [NUM_OUT-1:0]  o_y_bar
);

  always_comb begin
    o_y_bar = '1;
    if (!i_en_bar) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (i_sel == SEL_BITS'(i)) o_y_bar[i] = 1'b0;
      end
    end
  end

endmodule : onehot_bar_decoder
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : control_sequencer
//  Brief   : Microcode sequencer: IR, micro-step counter, halt/stall control
//            and one-hot active-low bus source/destination strobes
//  Rev     : 1.0  initial release
// ============================================================================
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int STEP_BITS = 3,
  parameter int NUM_CODES = 8
) (
  input  logic                   clk,
  input  logic                   reset_bar,
  input  logic [15:0]            bus,
  input  logic [15:0]            uinst,
  input  logic                   mem_ready,
  output logic [8+STEP_BITS-1:0] uaddr,
  output logic [NUM_CODES-1:0]   en_bar,
  output logic [NUM_CODES-1:0]   load_bar,
  output logic                   halted
);

  logic [STEP_BITS-1:0] r_step;
  logic [7:0]           r_ir;
  logic                 r_halted;

  uinst_t w_ui;
  logic   w_stall;
  logic   w_src_off;
  logic   w_dst_off;
  logic   w_last_step;
  logic   w_unused;

  assign w_ui        = uinst_t'(uinst);
  assign w_stall     = w_ui.wait_mem & ~mem_ready;
  assign w_last_step = w_ui.last | (r_step == {STEP_BITS{1'b1}});
  assign w_unused    = ^{bus[7:0], w_ui.rsvd};

  // Reset forces strobes high combinationally so no register is touched while
  // the asynchronous ROM is still returning garbage.
  assign w_src_off = ~reset_bar | r_halted | (w_ui.src == CODE_NONE);
  assign w_dst_off = ~reset_bar | r_halted | w_stall
                   | (w_ui.dst == CODE_NONE) | (w_ui.dst == CODE_IR);

  onehot_bar_decoder #(.NUM_OUT(NUM_CODES)) u_src_dec (
    .i_sel    (w_ui.src),
    .i_en_bar (w_src_off),
    .o_y_bar  (en_bar)
  );

  onehot_bar_decoder #(.NUM_OUT(NUM_CODES)) u_dst_dec (
    .i_sel    (w_ui.dst),
    .i_en_bar (w_dst_off),
    .o_y_bar  (load_bar)
  );

  // A halt step freezes everything, including the step reset an end would cause.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_step   <= '0;
      r_ir     <= 8'h00;
      r_halted <= 1'b0;
    end else if (!r_halted && !w_stall) begin
      if (w_ui.halt) begin
        r_halted <= 1'b1;
      end else begin
        if (w_ui.dst == CODE_IR) r_ir <= bus[15:8];
        r_step <= w_last_step ? '0 : r_step + 1'b1;
      end
    end
  end

  assign uaddr  = {r_ir, r_step};
  assign halted = r_halted;

endmodule : control_sequencer
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_control_sequencer
//  Brief   : Scoreboard bench for control_sequencer
//  Rev     : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_bar;
  logic [15:0] bus;
  logic [15:0] uinst;
  logic        mem_ready;
  logic [10:0] uaddr;
  logic [7:0]  en_bar;
  logic [7:0]  load_bar;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [10:0] uaddr;
    logic [7:0]  en;
    logic [7:0]  ld;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  control_sequencer #(.STEP_BITS(3), .NUM_CODES(8)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus       (bus),
    .uinst     (uinst),
    .mem_ready (mem_ready),
    .uaddr     (uaddr),
    .en_bar    (en_bar),
    .load_bar  (load_bar),
    .halted    (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe decode derived from the microinstruction fields and the given state.
  function automatic logic [7:0] exp_en(input logic [15:0] ui, input logic rst_b, input logic hlt);
    logic [7:0] v = 8'hFF;
    if (rst_b && !hlt && ui[2:0] != 3'd0) v[ui[2:0]] = 1'b0;
    return v;
  endfunction

  function automatic logic [7:0] exp_ld(input logic [15:0] ui, input logic rdy,
                                        input logic rst_b, input logic hlt);
    logic [7:0] v = 8'hFF;
    logic stall = ui[7] & ~rdy;
    if (rst_b && !hlt && !stall && ui[5:3] != 3'd0 && ui[5:3] != 3'd7) v[ui[5:3]] = 1'b0;
    return v;
  endfunction

  task automatic push_exp(input string tag, input logic [10:0] ua, input logic hlt);
    exp_t e;
    e.tag    = tag;
    e.uaddr  = ua;
    e.halted = hlt;
    e.en     = exp_en(uinst, reset_bar, hlt);
    e.ld     = exp_ld(uinst, mem_ready, reset_bar, hlt);
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".uaddr"},  32'(uaddr),    32'(e.uaddr));
    check({e.tag, ".en_bar"}, 32'(en_bar),   32'(e.en));
    check({e.tag, ".load"},   32'(load_bar), 32'(e.ld));
    check({e.tag, ".halted"}, 32'(halted),   32'(e.halted));
  endtask

  // Called just after a rising edge: drive, sample at the falling edge, then
  // cross the next rising edge.
  task automatic cyc(input logic [15:0] ui, input logic [15:0] b, input logic rdy,
                     input logic [10:0] ua, input logic hlt, input string tag);
    uinst     = ui;
    bus       = b;
    mem_ready = rdy;
    push_exp(tag, ua, hlt);
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_bar = 1'b0;
    uinst     = 16'h0009;
    bus       = 16'h0000;
    mem_ready = 1'b1;

    cyc(16'h0009, 16'hA500, 1'b1, 11'h000, 1'b0, "rst0");
    cyc(16'h0009, 16'hA500, 1'b1, 11'h000, 1'b0, "rst1");
    reset_bar = 1'b1;

    // First step after release: src1/dst1 with end, so step stays at 0.
    uinst = 16'h0049;
    #1;
    check("rel_en", 32'(en_bar), 32'h0FD);
    check("rel_ld", 32'(load_bar), 32'h0FD);
    cyc(16'h0049, 16'h0000, 1'b1, 11'h000, 1'b0, "rel");

    // Opcode fetch: dst=IR, src=2.
    cyc(16'h003A, 16'hA512, 1'b1, 11'h000, 1'b0, "fetch");
    cyc(16'h0040, 16'h0000, 1'b1, {8'hA5, 3'd1}, 1'b0, "fetch_end");
    cyc(16'h0000, 16'h0000, 1'b1, {8'hA5, 3'd0}, 1'b0, "op_s0");

    // Wait handshake: src4 dst3 wait.
    for (int i = 0; i < 3; i++)
      cyc(16'h009C, 16'h0000, 1'b0, {8'hA5, 3'd1}, 1'b0, "wait_stall");
    uinst = 16'h009C;
    mem_ready = 1'b1;
    #1;
    check("wait_rdy_ld", 32'(load_bar), 32'h0F7);
    cyc(16'h009C, 16'h0000, 1'b1, {8'hA5, 3'd1}, 1'b0, "wait_rdy");
    cyc(16'h0040, 16'h0000, 1'b1, {8'hA5, 3'd2}, 1'b0, "wait_adv");

    // Eight steps without end: step 0..7 then wraps, IR untouched.
    for (int i = 0; i < 8; i++)
      cyc(16'h0011, 16'hFF00, 1'b1, {8'hA5, 3'(i)}, 1'b0, "wrap");

    cyc(16'h0012, 16'h0000, 1'b1, {8'hA5, 3'd0}, 1'b0, "self_load");

    // End and IR load together: next cycle is step 0 of the new opcode.
    cyc(16'h0079, 16'h3C00, 1'b1, {8'hA5, 3'd1}, 1'b0, "end_ir");

    // Halt with wait not ready is not taken.
    cyc(16'h0180, 16'h0000, 1'b0, {8'h3C, 3'd0}, 1'b0, "halt_wait0");
    cyc(16'h0180, 16'h0000, 1'b0, {8'h3C, 3'd0}, 1'b0, "halt_wait1");

    // Halt with end: halted wins and step is not reset.
    cyc(16'h0141, 16'h0000, 1'b1, {8'h3C, 3'd0}, 1'b0, "halt_end");
    for (int i = 0; i < 10; i++)
      cyc(16'h003A + 16'(i), 16'hA500, 1'b1, {8'h3C, 3'd0}, 1'b1, "halted");
    check("halted_flag", 32'(halted), 32'd1);

    // Asynchronous reset between edges.
    uinst = 16'h0009;
    #2;
    reset_bar = 1'b0;
    #1;
    push_exp("mid_rst", 11'h000, 1'b0);
    pop_cmp();
    @(posedge clk);
    #1;
    reset_bar = 1'b1;
    cyc(16'h0009, 16'h0000, 1'b1, 11'h000, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_control_sequencer
`default_nettype wire
